// File: rtl/alu_op_encoder_pkg.sv
// Shared opcode, ALU_op, funct and FSM encodings for the WISC ALU op encoder
// and the ALU control decoder that consumes its output.
package alu_op_encoder_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_SIIC  = 5'b00010;
  localparam logic [4:0] OP_RTI   = 5'b00011;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHFT  = 5'b11010;
  localparam logic [4:0] OP_ARITH = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;

  localparam logic [4:0] ALU_ARITH = 5'b00000;
  localparam logic [4:0] ALU_SHIFT = 5'b00001;
  localparam logic [4:0] ALU_SEQ   = 5'b00010;
  localparam logic [4:0] ALU_SLT   = 5'b00011;
  localparam logic [4:0] ALU_SLE   = 5'b00100;
  localparam logic [4:0] ALU_SCO   = 5'b00101;
  localparam logic [4:0] ALU_BTR   = 5'b00110;
  localparam logic [4:0] ALU_ADDR  = 5'b00111;
  localparam logic [4:0] ALU_SUBI  = 5'b01000;
  localparam logic [4:0] ALU_XORI  = 5'b01001;
  localparam logic [4:0] ALU_ANDNI = 5'b01010;
  localparam logic [4:0] ALU_ROLI  = 5'b01011;
  localparam logic [4:0] ALU_SLLI  = 5'b01100;
  localparam logic [4:0] ALU_RORI  = 5'b01101;
  localparam logic [4:0] ALU_SRLI  = 5'b01110;
  localparam logic [4:0] ALU_SLBI  = 5'b01111;
  localparam logic [4:0] ALU_BR    = 5'b10000;

  localparam logic [1:0] FN_NONE = 2'b00;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] funct;
    logic [4:0] alu_op;
    logic       alu_used;
    logic       illegal;
    logic       halt;
  } enc_t;

endpackage

// File: rtl/alu_op_enc_lut.sv
// Combinational map from a WISC instruction word to its ALU control bundle.
module alu_op_enc_lut
  import alu_op_encoder_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic [1:0]  o_funct,
  output logic [4:0]  o_alu_op,
  output logic        o_alu_used,
  output logic        o_illegal,
  output logic        o_halt
);

  logic [4:0] w_op;
  assign w_op = i_instr[15:11];

  always_comb begin
    o_funct    = FN_NONE;
    o_alu_op   = ALU_ADDR;
    o_alu_used = 1'b1;
    o_illegal  = 1'b0;
    o_halt     = 1'b0;
    unique case (w_op)
      OP_HALT: begin
        o_alu_used = 1'b0;
        o_halt     = 1'b1;
      end
      OP_NOP, OP_J, OP_JAL, OP_LBI:
        o_alu_used = 1'b0;
      OP_SIIC, OP_RTI: begin
        o_alu_used = 1'b0;
        o_illegal  = 1'b1;
      end
      OP_ARITH: begin
        o_alu_op = ALU_ARITH;
        o_funct  = i_instr[1:0];
      end
      OP_SHFT: begin
        o_alu_op = ALU_SHIFT;
        o_funct  = i_instr[1:0];
      end
      OP_SEQ:   o_alu_op = ALU_SEQ;
      OP_SLT:   o_alu_op = ALU_SLT;
      OP_SLE:   o_alu_op = ALU_SLE;
      OP_SCO:   o_alu_op = ALU_SCO;
      OP_BTR:   o_alu_op = ALU_BTR;
      OP_ADDI, OP_ST, OP_LD, OP_STU, OP_JR, OP_JALR:
        o_alu_op = ALU_ADDR;
      OP_SUBI:  o_alu_op = ALU_SUBI;
      OP_XORI:  o_alu_op = ALU_XORI;
      OP_ANDNI: o_alu_op = ALU_ANDNI;
      OP_ROLI:  o_alu_op = ALU_ROLI;
      OP_SLLI:  o_alu_op = ALU_SLLI;
      OP_RORI:  o_alu_op = ALU_RORI;
      OP_SRLI:  o_alu_op = ALU_SRLI;
      OP_SLBI:  o_alu_op = ALU_SLBI;
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ:
        o_alu_op = ALU_BR;
      default:  o_alu_op = ALU_ADDR;
    endcase
  end

endmodule

// File: rtl/alu_op_encoder.sv
// Registered decode-to-execute ALU op encoder with flush and HALT parking.
// Define ALU_OP_ENC_SKID_EN for a one-entry skid buffer and flopped in_ready.
module alu_op_encoder
  import alu_op_encoder_pkg::*;
#(
  parameter int SKID_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  funct,
  output logic [4:0]  ALU_op,
  output logic        alu_used,
  output logic        illegal,
  output logic        halt
);

  generate
    if (SKID_DEPTH != 1) begin : g_bad_depth
      $error("alu_op_encoder: SKID_DEPTH must be 1");
    end
  endgenerate

  state_t r_state;
  enc_t   r_out;
  logic   r_valid;
  enc_t   w_enc;
  logic   w_take;
  logic   w_fire;

  alu_op_enc_lut u_lut (
    .i_instr    (instr),
    .o_funct    (w_enc.funct),
    .o_alu_op   (w_enc.alu_op),
    .o_alu_used (w_enc.alu_used),
    .o_illegal  (w_enc.illegal),
    .o_halt     (w_enc.halt)
  );

  assign w_take    = in_valid && in_ready;
  assign w_fire    = r_valid && out_ready;
  assign out_valid = r_valid;
  assign funct     = r_out.funct;
  assign ALU_op    = r_out.alu_op;
  assign alu_used  = r_out.alu_used;
  assign illegal   = r_out.illegal;
  assign halt      = r_out.halt;

`ifdef ALU_OP_ENC_SKID_EN
  enc_t r_skid;
  logic r_skid_valid;
  logic r_in_ready;

  assign in_ready = r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= (r_state == ST_RUN);
    end else if (w_fire && r_out.halt) begin
      r_state      <= ST_HALTED;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else if (!r_valid || out_ready) begin
      r_in_ready <= (r_state == ST_RUN);
      // The skid entry is older than anything on the input port.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_valid      <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_take) begin
        r_out   <= w_enc;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_take) begin
      r_skid       <= w_enc;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end
`else
  assign in_ready = (r_state == ST_RUN) && (!r_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_fire && r_out.halt) begin
      r_state <= ST_HALTED;
      r_valid <= 1'b0;
    end else if (w_take) begin
      r_out   <= w_enc;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_encoder.sv
// Scoreboard bench for alu_op_encoder: random traffic plus directed
// handshake, stall, HALT, flush and reset scenarios.
module tb_alu_op_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  funct;
  logic [4:0]  ALU_op;
  logic        alu_used;
  logic        illegal;
  logic        halt;

  always #5 clk = ~clk;

  alu_op_encoder #(.SKID_DEPTH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .funct     (funct),
    .ALU_op    (ALU_op),
    .alu_used  (alu_used),
    .illegal   (illegal),
    .halt      (halt)
  );

`ifdef ALU_OP_ENC_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] f;
    logic [4:0] op;
    logic       used;
    logic       ill;
    logic       hlt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   halted_m = 1'b0;

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    int o;
    o = int'(ins[15:11]);
    e = '{f: 2'd0, op: 5'd7, used: 1'b1, ill: 1'b0, hlt: 1'b0};
    if (o == 0 || o == 1 || o == 4 || o == 6 || o == 24) e.used = 1'b0;
    else if (o == 2 || o == 3) begin
      e.used = 1'b0;
      e.ill  = 1'b1;
    end
    else if (o == 27) begin e.op = 5'd0; e.f = ins[1:0]; end
    else if (o == 26) begin e.op = 5'd1; e.f = ins[1:0]; end
    else if (o >= 28) e.op = 5'(o - 26);
    else if (o == 25) e.op = 5'd6;
    else if (o >= 20 && o <= 23) e.op = 5'(o - 9);
    else if (o == 18) e.op = 5'd15;
    else if (o >= 12 && o <= 15) e.op = 5'd16;
    else if (o >= 9 && o <= 11) e.op = 5'(o - 1);
    e.hlt = (o == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    if (halted_m) return 1'b0;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  // One clock of stimulus; returns just before the next rising edge.
  task automatic cycle(input logic v, input logic [15:0] ins,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    instr     = ins;
    out_ready = ordy;
    flush     = fl;
    #3;
    chk("in_ready", in_ready, exp_ready());
    if (fl) q.delete();
    else if (v && in_ready) q.push_back(model(ins));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    #3;
    q.delete();
    halted_m = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_funct", funct, 0);
    chk("rst_alu_op", ALU_op, 0);
    chk("rst_alu_used", alu_used, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_halt", halt, 0);
    chk("rst_in_ready", in_ready, SKID ? 0 : 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      cycle(1'b0, 16'h0800, 1'b1, 1'b0);
      n++;
    end
    cycle(1'b0, 16'h0800, 1'b1, 1'b0);
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: pops on every output transfer, checks stall stability and flush.
  initial begin
    logic       prev_stall;
    logic       prev_flush;
    logic [9:0] prev_b;
    logic [9:0] b;
    exp_t       e;
    prev_stall = 1'b0;
    prev_flush = 1'b0;
    prev_b     = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
        prev_flush = 1'b0;
        continue;
      end
      b = {funct, ALU_op, alu_used, illegal, halt};
      if (prev_flush) chk("flush_clears", out_valid, 0);
      else if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_stable", b, prev_b);
      end
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("bundle", b, e);
          if (e.hlt) halted_m = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_flush = flush;
      prev_b     = b;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    do_reset();

    cycle(1'b1, 16'hD94D, 1'b1, 1'b0);
    cycle(1'b0, 16'h0800, 1'b1, 1'b0);
    chk("d94d_latency", out_valid, 1);
    chk("d94d_funct", funct, 2'b01);
    chk("d94d_alu_op", ALU_op, 5'b00000);
    chk("d94d_used", alu_used, 1);
    chk("d94d_illegal", illegal, 0);

    cycle(1'b1, 16'h4123, 1'b1, 1'b0);
    cycle(1'b1, 16'h6100, 1'b1, 1'b0);
    chk("addi_valid", out_valid, 1);
    chk("addi_op", ALU_op, 5'b00111);
    cycle(1'b0, 16'h0800, 1'b1, 1'b0);
    chk("beqz_valid", out_valid, 1);
    chk("beqz_op", ALU_op, 5'b10000);

    cycle(1'b1, 16'h1000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0800, 1'b1, 1'b0);
    chk("siic_illegal", illegal, 1);
    chk("siic_used", alu_used, 0);
    chk("siic_op", ALU_op, 5'b00111);
    drain();

    cycle(1'b1, 16'hA000, 1'b1, 1'b0);
    cycle(1'b1, 16'hB000, 1'b0, 1'b0);
    cycle(1'b1, 16'hE000, 1'b0, 1'b0);
    cycle(1'b1, 16'hF000, 1'b0, 1'b0);
    chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h9000, 1'b1, 1'b0);
    drain();

    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom);
      if (r[15:11] == 5'd0) r[15:11] = 5'd1;
      if ($urandom_range(0, 99) < 4)
        cycle($urandom_range(0, 1) == 1, r, 1'b0, 1'b1);
      else
        cycle($urandom_range(0, 9) < 7, r,
              $urandom_range(0, 9) < 7, 1'b0);
    end
    drain();

    cycle(1'b1, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0800, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h4123, 1'b1, 1'b0);
    chk("halted_in_ready", in_ready, 0);
    cycle(1'b0, 16'h0800, 1'b0, 1'b1);
    cycle(1'b1, 16'h4123, 1'b1, 1'b0);
    chk("halt_after_flush", in_ready, 0);

    cycle(1'b1, 16'hD94D, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 16'hD94D, 1'b1, 1'b0);
    chk("run_after_rst", in_ready, 1);
    drain();

    cycle(1'b1, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0800, 1'b0, 1'b1);
    cycle(1'b0, 16'h0800, 1'b1, 1'b0);
    chk("halt_squash_valid", out_valid, 0);
    chk("halt_squash_ready", in_ready, 1);
    cycle(1'b1, 16'h4123, 1'b1, 1'b0);
    cycle(1'b0, 16'h0800, 1'b1, 1'b0);
    chk("after_squash_valid", out_valid, 1);
    chk("after_squash_op", ALU_op, 5'b00111);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
